// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB constants: port count, widths, the reserved "no producer" label
// and the fixed result-port numbering.
package cdb_arbiter_pkg;

  localparam int NUM_CDB_PORTS = 4;
  localparam int DATA_W        = 32;
  localparam int TAG_W         = 4;

  localparam logic [TAG_W-1:0] NO_LABEL = '0;

  localparam int PORT_ALU = 0;
  localparam int PORT_MUL = 1;
  localparam int PORT_LD  = 2;
  localparam int PORT_BR  = 3;

  function automatic logic [NUM_CDB_PORTS-1:0] port_onehot(input logic [1:0] idx);
    logic [NUM_CDB_PORTS-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/cdb_port_fifo.sv
// Per-port result FIFO: DEPTH entries of {label, data}, combinational head,
// synchronous flush that empties it without touching the storage.
module cdb_port_fifo #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [DATA_W-1:0]      push_data,
  input  logic [TAG_W-1:0]       push_label,
  input  logic                   pop,
  input  logic                   flush,
  output logic [DATA_W-1:0]      head_data,
  output logic [TAG_W-1:0]       head_label,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [TAG_W+DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic                    full;
  logic                    do_push;
  logic                    do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  assign {head_label, head_data} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= {push_label, push_data};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus sequencer: four result FIFOs, round-robin pick of one head
// per cycle, registered broadcast stage snooped by RS and register file.
module cdb_arbiter #(
  parameter int DATA_W = cdb_arbiter_pkg::DATA_W,
  parameter int TAG_W  = cdb_arbiter_pkg::TAG_W,
  parameter int DEPTH  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          in_valid,
  input  logic [4*DATA_W-1:0] in_data,
  input  logic [4*TAG_W-1:0]  in_label,
  output logic [3:0]          in_ready,
  input  logic                flush,
  output logic                cdb_valid,
  output logic [DATA_W-1:0]   cdb_data,
  output logic [TAG_W-1:0]    cdb_label,
  output logic [3:0]          cdb_src,
  output logic                drop_err
);

  import cdb_arbiter_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] head_data  [NUM_CDB_PORTS];
  logic [TAG_W-1:0]  head_label [NUM_CDB_PORTS];
  logic [CW-1:0]     fifo_count [NUM_CDB_PORTS];
  logic [NUM_CDB_PORTS-1:0] fifo_empty;
  logic [NUM_CDB_PORTS-1:0] push_req;
  logic [NUM_CDB_PORTS-1:0] drop_hit;
  logic [NUM_CDB_PORTS-1:0] pop_req;

  logic [1:0] rr_ptr;
  logic [1:0] winner;
  logic       found;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CDB_PORTS; gi++) begin : g_port
      logic          accept;
      logic          is_null;

      assign in_ready[gi]  = (fifo_count[gi] < CW'(DEPTH));
      assign accept        = in_valid[gi] && in_ready[gi] && !flush;
      assign is_null       = (in_label[gi*TAG_W +: TAG_W] == TAG_W'(NO_LABEL));
      assign push_req[gi]  = accept && !is_null;
      assign drop_hit[gi]  = accept && is_null;
      assign pop_req[gi]   = found && (winner == 2'(gi));

      cdb_port_fifo #(
        .DATA_W (DATA_W),
        .TAG_W  (TAG_W),
        .DEPTH  (DEPTH)
      ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_req[gi]),
        .push_data  (in_data[gi*DATA_W +: DATA_W]),
        .push_label (in_label[gi*TAG_W +: TAG_W]),
        .pop        (pop_req[gi]),
        .flush      (flush),
        .head_data  (head_data[gi]),
        .head_label (head_label[gi]),
        .count      (fifo_count[gi]),
        .empty      (fifo_empty[gi])
      );
    end
  endgenerate

  // Search starts just after the last winner; k=4 wraps back to rr_ptr itself.
  always_comb begin
    logic [1:0] idx;
    found  = 1'b0;
    winner = rr_ptr;
    idx    = rr_ptr;
    for (int k = 1; k <= NUM_CDB_PORTS; k++) begin
      idx = rr_ptr + 2'(k);
      if (!found && !fifo_empty[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= 2'(PORT_BR);
      cdb_valid <= 1'b0;
      cdb_data  <= '0;
      cdb_label <= '0;
      cdb_src   <= '0;
      drop_err  <= 1'b0;
    end else begin
      drop_err <= drop_err | (|drop_hit);
      if (flush || !found) begin
        cdb_valid <= 1'b0;
        cdb_src   <= '0;
      end else begin
        rr_ptr    <= winner;
        cdb_valid <= 1'b1;
        cdb_data  <= head_data[winner];
        cdb_label <= head_label[winner];
        cdb_src   <= port_onehot(winner);
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: stimulus enqueues expected broadcasts,
// a negedge monitor pops and compares whatever appears on the CDB.
module tb_cdb_arbiter;

  localparam int DW = 32;
  localparam int TW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      in_valid;
  logic [4*DW-1:0] in_data;
  logic [4*TW-1:0] in_label;
  logic [3:0]      in_ready;
  logic            flush;
  logic            cdb_valid;
  logic [DW-1:0]   cdb_data;
  logic [TW-1:0]   cdb_label;
  logic [3:0]      cdb_src;
  logic            drop_err;

  typedef struct {
    logic [3:0]    src;
    logic [TW-1:0] label;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  cdb_arbiter #(.DATA_W(DW), .TAG_W(TW), .DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_label  (in_label),
    .in_ready  (in_ready),
    .flush     (flush),
    .cdb_valid (cdb_valid),
    .cdb_data  (cdb_data),
    .cdb_label (cdb_label),
    .cdb_src   (cdb_src),
    .drop_err  (drop_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic expect_bcast(input logic [3:0] src, input logic [TW-1:0] lbl, input logic [DW-1:0] d);
    exp_t e;
    e.src = src; e.label = lbl; e.data = d;
    sb.push_back(e);
  endtask

  task automatic set_port(input int p, input logic [TW-1:0] lbl, input logic [DW-1:0] d);
    in_valid[p]           = 1'b1;
    in_label[p*TW +: TW]  = lbl;
    in_data[p*DW +: DW]   = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = '0;
    end
  endtask

  task automatic drain(input string name);
    int waited = 0;
    while (sb.size() != 0 && waited < 30) begin
      @(negedge clk);
      in_valid = '0;
      waited++;
    end
    check(name, sb.size(), 0);
  endtask

  // Monitor: every valid broadcast must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && cdb_valid) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_bcast: got src=%b label=%0d data=0x%0h, expected no broadcast",
                 cdb_src, cdb_label, cdb_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("cdb_src", 32'(cdb_src), 32'(e.src));
        check("cdb_label", 32'(cdb_label), 32'(e.label));
        check("cdb_data", cdb_data, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200us");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] exp_rdy;
    logic [TW-1:0] lbl;

    rst_n    = 1'b0;
    in_valid = '0;
    in_data  = '0;
    in_label = '0;
    flush    = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'hF);
    check("rst_cdb_valid", 32'(cdb_valid), 0);
    check("rst_cdb_src", 32'(cdb_src), 0);
    check("rst_cdb_data", cdb_data, 0);
    check("rst_cdb_label", 32'(cdb_label), 0);
    check("rst_drop_err", 32'(drop_err), 0);
    rst_n = 1'b1;
    idle(2);
    check("idle_cdb_valid", 32'(cdb_valid), 0);
    check("idle_in_ready", 32'(in_ready), 32'hF);

    // Single push on port 2: visible two edges later, then gone
    @(negedge clk);
    set_port(2, 4'd5, 32'hDEADBEEF);
    expect_bcast(4'b0100, 4'd5, 32'hDEADBEEF);
    @(negedge clk);
    in_valid = '0;
    check("lat_edge1_valid", 32'(cdb_valid), 0);
    @(negedge clk);
    check("lat_edge2_valid", 32'(cdb_valid), 1);
    @(negedge clk);
    check("single_after_valid", 32'(cdb_valid), 0);
    check("single_after_src", 32'(cdb_src), 0);

    // Mid-burst async reset; last winner was port 2 so port 3 goes first
    @(negedge clk);
    for (int p = 0; p < 4; p++) set_port(p, TW'(p + 1), 32'h1111_0000 + 32'(p));
    expect_bcast(4'b1000, 4'd4, 32'h1111_0003);
    @(negedge clk);
    in_valid = '0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(cdb_valid), 0);
    check("async_rst_src", 32'(cdb_src), 0);
    check("async_rst_data", cdb_data, 0);
    check("async_rst_label", 32'(cdb_label), 0);
    check("async_rst_in_ready", 32'(in_ready), 32'hF);
    @(negedge clk);
    rst_n = 1'b1;

    // All four ports at once from reset: port0..port3 in order
    @(negedge clk);
    for (int p = 0; p < 4; p++) set_port(p, TW'(p + 1), 32'h2000_0000 + 32'(p));
    expect_bcast(4'b0001, 4'd1, 32'h2000_0000);
    expect_bcast(4'b0010, 4'd2, 32'h2000_0001);
    expect_bcast(4'b0100, 4'd3, 32'h2000_0002);
    expect_bcast(4'b1000, 4'd4, 32'h2000_0003);
    @(negedge clk);
    in_valid = '0;
    drain("drain_all4");

    // Port 0 alone moves the pointer to 0 so the next search starts at port 1
    @(negedge clk);
    set_port(0, 4'd15, 32'h0000_00FF);
    expect_bcast(4'b0001, 4'd15, 32'h0000_00FF);
    @(negedge clk);
    in_valid = '0;
    drain("drain_p0");

    // Port 1 streams 6..12 while ports 0 and 3 push once
    expect_bcast(4'b0010, 4'd6,  32'hA000_0006);
    expect_bcast(4'b1000, 4'd11, 32'hB000_0011);
    expect_bcast(4'b0001, 4'd10, 32'hB000_0010);
    for (int l = 7; l <= 12; l++) expect_bcast(4'b0010, TW'(l), 32'hA000_0000 + 32'(l));
    lbl = 4'd6;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      in_valid = '0;
      exp_rdy = (c == 3 || c == 4) ? 4'b1101 : 4'b1111;
      check($sformatf("stream_in_ready_c%0d", c), 32'(in_ready), 32'(exp_rdy));
      set_port(1, lbl, 32'hA000_0000 + 32'(lbl));
      if (c == 0) begin
        set_port(0, 4'd10, 32'hB000_0010);
        set_port(3, 4'd11, 32'hB000_0011);
      end
      if (exp_rdy[1]) lbl = lbl + 4'd1;
    end
    @(negedge clk);
    in_valid = '0;
    drain("drain_stream");

    // Flush with port 0 full; push in the flush cycle must vanish
    @(negedge clk);
    set_port(0, 4'd1, 32'hC000_0001);
    set_port(2, 4'd2, 32'hC000_0002);
    expect_bcast(4'b0100, 4'd2, 32'hC000_0002);
    @(negedge clk);
    in_valid = '0;
    set_port(0, 4'd3, 32'hC000_0003);
    set_port(2, 4'd4, 32'hC000_0004);
    @(negedge clk);
    in_valid = '0;
    check("pre_flush_in_ready", 32'(in_ready), 32'b1110);
    flush = 1'b1;
    set_port(1, 4'd5, 32'hC000_0005);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = '0;
    check("flush_valid", 32'(cdb_valid), 0);
    check("flush_src", 32'(cdb_src), 0);
    check("flush_in_ready", 32'(in_ready), 32'hF);
    idle(5);
    check("flush_quiet", sb.size(), 0);

    // Label-0 push is dropped and sets the sticky error
    check("drop_err_before", 32'(drop_err), 0);
    @(negedge clk);
    set_port(3, 4'd0, 32'h0000_1234);
    @(negedge clk);
    in_valid = '0;
    check("drop_err_set", 32'(drop_err), 1);
    idle(3);
    check("drop_err_sticky", 32'(drop_err), 1);
    check("drop_in_ready", 32'(in_ready), 32'hF);
    @(negedge clk);
    set_port(3, 4'd9, 32'h0000_0099);
    expect_bcast(4'b1000, 4'd9, 32'h0000_0099);
    @(negedge clk);
    in_valid = '0;
    drain("drain_label9");
    check("drop_err_end", 32'(drop_err), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
